sa3x3_ctrl: RTL and testbench
=============================

Name: sa3x3_ctrl

Overview:
Sequencer for the 3x3 weight-stationary systolic array (sa3x3).
- Accepts a weight matrix and a stream of 3-element activation vectors.
- Drives the array's clear and weight_load, skews activations into rows, ties the top partial sums to zero, and de-skews the column outputs into one aligned result vector per input.
- Sits between the DMA/buffer front end and the array instance.

Parameters:
DATA_W, 8, element width; must equal the array's 8-bit datapath.
PIPE_LAT, 6, accept-to-output latency in clock edges; fixed by the array timing below and not to be overridden.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
cfg_valid  in  1  weight matrix offered.
cfg_ready  out  1  controller can accept weights (IDLE only).
cfg_weights  in  72  w_rc at bits [((r-1)*3+(c-1))*8 +: 8].
start  in  1  rerun a batch with the stored weights (IDLE only).
in_valid  in  1  activation vector valid.
in_ready  out  1  controller accepts a vector (RUN only).
in_data  in  24  act row r at bits [(r-1)*8 +: 8].
in_last  in  1  final vector of the batch.
out_valid  out  1  result vector valid; single-cycle pulse per vector, no backpressure.
out_data  out  24  column c result at bits [(c-1)*8 +: 8].
out_last  out  1  qualifies the result of the in_last vector.
busy  out  1  high in every state except IDLE.
sa_clear  out  1  to array clear.
sa_weight_load  out  1  to array weight_load.
sa_w  out  72  to array w_11..w_33, same packing as cfg_weights.
sa_act_in  out  24  to array act_in1..3.
sa_psum_in  out  24  to array psum_in1..3; constant 0.
sa_psum_out  in  24  from array psum_out1..3.

Behaviour:
- Reset: all registers cleared; all outputs 0; state IDLE; in-flight results discarded, with no out_valid emitted after reset.
- Array timing contract: a_out and psum_out are each registered once per PE. Each result column wraps mod 256; the controller performs no arithmetic.
- FSM states: IDLE, CLR, LOAD, RUN, DRAIN.
- IDLE:
  - cfg_ready=1, in_ready=0.
  - A cfg handshake latches cfg_weights into the weight register, which drives sa_w continuously, and moves to CLR.
  - start alone also moves to CLR.
  - If cfg and start occur in the same cycle, the cfg is taken and only one sequence runs.
- CLR: sa_clear=1 for exactly 1 cycle, then LOAD.
- LOAD: sa_weight_load=1 for exactly 1 cycle, then RUN.
- RUN:
  - in_ready=1. Each accepted vector enters the skew line.
  - Idle cycles inject 0 activations with the valid tag 0.
  - Acceptance with in_last=1 moves to DRAIN.
- DRAIN:
  - in_ready=0. Waits until the valid/last tag pipeline is empty, which takes at most PIPE_LAT cycles, then returns to IDLE.
  - cfg and start are ignored outside IDLE.
- Input skew (vector accepted at edge E0):
  - Row 1 presented during the cycle after E0.
  - Row 2 one cycle later than row 1.
  - Row 3 two cycles later than row 1.
- Output de-skew:
  - Column 1 delayed 2 registers, column 2 delayed 1, column 3 delayed 0.
  - All three columns then go through one output register.
- Latency: out_valid and out_data become valid at edge E0+6 and hold for one cycle. Back-to-back accepts give back-to-back results in order.
- Tag pipeline: a 6-deep shift register of {valid, last} aligned to the data path.
- Throughput: 1 vector/cycle in RUN.

Decomposition:
- Package sa_ctrl_pkg: state enum, DATA_W, N_ROWS=3, N_COLS=3, PIPE_LAT=6.
- Sub-module sa_skew_line (parameterised depth and width DATA_W, async-reset register chain). Instantiated per row for the input skew and per column for the output de-skew.

Test Plan:
- Identity weights (w_11=w_22=w_33=1, others 0), accept [1,2,3] at E0 -> out_data=[1,2,3] with out_valid and out_last high at E0+6 only.
- All weights 1, vectors [1,2,3],[4,5,6],[7,8,9] back-to-back with in_last on the third -> [6,6,6],[15,15,15],[24,24,24] on consecutive cycles; out_last only on the third; busy drops after DRAIN.
- All weights 100, input [1,1,1] -> out_data=[44,44,44] (300 mod 256).
- cfg_valid and start in the same IDLE cycle -> exactly one sa_clear pulse followed by one sa_weight_load pulse; sa_w equals cfg_weights; cfg_ready low until back in IDLE.
- Gapped input: in_valid toggling 1,0,1 -> results exactly 6 edges after each accept with no spurious out_valid; start then reruns the batch with unchanged sa_w.
- rst asserted mid-RUN with 3 vectors in flight -> all outputs 0 immediately, no out_valid afterwards, FSM in IDLE with cfg_ready=1.

Source files
------------

// File: rtl/sa_ctrl_pkg.sv
// Shared sizing constants and state encoding for the 3x3 systolic array sequencer.
package sa_ctrl_pkg;

   localparam int DATA_W   = 8;
   localparam int N_ROWS   = 3;
   localparam int N_COLS   = 3;
   localparam int PIPE_LAT = 6;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CLR   = 3'd1;
   localparam state_t ST_LOAD  = 3'd2;
   localparam state_t ST_RUN   = 3'd3;
   localparam state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth register chain used to stagger activations into rows and realign column sums.
module sa_skew_line
   import sa_ctrl_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sa3x3_ctrl.sv
// Sequencer for the 3x3 weight-stationary array: loads weights, skews activations into
// the rows and realigns the column sums into one result vector per accepted input.
module sa3x3_ctrl
   import sa_ctrl_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic [N_ROWS*N_COLS*DATA_W-1:0] cfg_weights,
   input  logic                            start,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [N_ROWS*DATA_W-1:0]        in_data,
   input  logic                            in_last,
   output logic                            out_valid,
   output logic [N_COLS*DATA_W-1:0]        out_data,
   output logic                            out_last,
   output logic                            busy,
   output logic                            sa_clear,
   output logic                            sa_weight_load,
   output logic [N_ROWS*N_COLS*DATA_W-1:0] sa_w,
   output logic [N_ROWS*DATA_W-1:0]        sa_act_in,
   output logic [N_COLS*DATA_W-1:0]        sa_psum_in,
   input  logic [N_COLS*DATA_W-1:0]        sa_psum_out
);

   state_t                            state_q, state_d;
   logic [N_ROWS*N_COLS*DATA_W-1:0]   weights_q, weights_d;
   logic [PIPE_LAT-1:0]               tagValid_q, tagLast_q;
   logic                              outValid_q, outLast_q;
   logic [N_COLS*DATA_W-1:0]          outData_q;
   logic                              accept;
   logic                              tagsPending;
   logic [N_ROWS*DATA_W-1:0]          actIn;
   logic [N_COLS*DATA_W-1:0]          colAligned;

   assign cfg_ready      = (state_q == ST_IDLE);
   assign in_ready       = (state_q == ST_RUN);
   assign busy           = (state_q != ST_IDLE);
   assign sa_clear       = (state_q == ST_CLR);
   assign sa_weight_load = (state_q == ST_LOAD);
   assign sa_w           = weights_q;
   assign sa_psum_in     = '0;
   assign accept         = in_valid & in_ready;

   // The oldest tag shifts out on the next edge, so only the younger stages keep DRAIN alive.
   assign tagsPending = |tagValid_q[PIPE_LAT-2:0];

   always_comb begin
      state_d   = state_q;
      weights_d = weights_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               weights_d = cfg_weights;
               state_d   = ST_CLR;
            end else if (start) begin
               state_d = ST_CLR;
            end
         end
         ST_CLR:   state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_RUN;
         ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
         ST_DRAIN: if (!tagsPending) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         weights_q  <= '0;
         tagValid_q <= '0;
         tagLast_q  <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
         outData_q  <= '0;
      end else begin
         state_q    <= state_d;
         weights_q  <= weights_d;
         tagValid_q <= {tagValid_q[PIPE_LAT-2:0], accept};
         tagLast_q  <= {tagLast_q[PIPE_LAT-2:0], accept & in_last};
         outValid_q <= tagValid_q[PIPE_LAT-1];
         outLast_q  <= tagLast_q[PIPE_LAT-1];
         outData_q  <= colAligned;
      end
   end

   // Cycles without an accepted vector push zeros so stale activations never reach the array.
   assign actIn = accept ? in_data : '0;

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      sa_skew_line #(
         .DEPTH(r + 1),
         .WIDTH(DATA_W)
      ) u_skew (
         .clk(clk),
         .rst(rst),
         .d_i(actIn[r*DATA_W +: DATA_W]),
         .q_o(sa_act_in[r*DATA_W +: DATA_W])
      );
   end

   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      if (c < N_COLS - 1) begin : g_delay
         sa_skew_line #(
            .DEPTH(N_COLS - 1 - c),
            .WIDTH(DATA_W)
         ) u_deskew (
            .clk(clk),
            .rst(rst),
            .d_i(sa_psum_out[c*DATA_W +: DATA_W]),
            .q_o(colAligned[c*DATA_W +: DATA_W])
         );
      end else begin : g_pass
         assign colAligned[c*DATA_W +: DATA_W] = sa_psum_out[c*DATA_W +: DATA_W];
      end
   end

   assign out_valid = outValid_q;
   assign out_last  = outLast_q;
   assign out_data  = outData_q;

endmodule

// File: tb/tb_sa3x3_ctrl.sv
// Directed bench for sa3x3_ctrl driving a behavioural model of the 3x3 weight-stationary array.
module tb_sa3x3_ctrl;

   localparam logic [71:0] W_IDENT = 72'h01_00_00_00_01_00_00_00_01;
   localparam logic [71:0] W_ONES  = {9{8'h01}};
   localparam logic [71:0] W_100   = {9{8'h64}};

   logic        clk, rst, cfg_valid, start, in_valid, in_last;
   logic [71:0] cfg_weights;
   logic [23:0] in_data;
   logic        cfg_ready, in_ready, out_valid, out_last, busy, sa_clear, sa_weight_load;
   logic [23:0] out_data, sa_act_in, sa_psum_in, sa_psum_out;
   logic [71:0] sa_w;

   int vectors;
   int miscompares;

   sa3x3_ctrl dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_weights(cfg_weights),
      .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .busy(busy),
      .sa_clear(sa_clear), .sa_weight_load(sa_weight_load), .sa_w(sa_w),
      .sa_act_in(sa_act_in), .sa_psum_in(sa_psum_in), .sa_psum_out(sa_psum_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Array model: activations move right and partial sums move down, one register per PE.
   logic [7:0] mA [3][3];
   logic [7:0] mP [3][3];
   logic [7:0] mW [3][3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               mA[r][c] <= 8'h00;
               mP[r][c] <= 8'h00;
               mW[r][c] <= 8'h00;
            end
         end
      end else begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               if (sa_weight_load) mW[r][c] <= sa_w[(r*3+c)*8 +: 8];
               if (sa_clear) begin
                  mA[r][c] <= 8'h00;
                  mP[r][c] <= 8'h00;
               end else begin
                  mA[r][c] <= (c == 0) ? sa_act_in[r*8 +: 8] : mA[r][c-1];
                  mP[r][c] <= ((r == 0) ? sa_psum_in[c*8 +: 8] : mP[r-1][c])
                              + mW[r][c] * ((c == 0) ? sa_act_in[r*8 +: 8] : mA[r][c-1]);
               end
            end
         end
      end
   end

   assign sa_psum_out = {mP[2][2], mP[2][1], mP[2][0]};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [23:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   // Offers a weight matrix in IDLE and walks through CLR and LOAD into RUN.
   task automatic configureAndRun(input logic [71:0] w);
      cfg_weights = w;
      cfg_valid   = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      vectors++;
      if (cfg_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_cfg_ready: got %b expected 1", cfg_ready);
      end
      vectors++;
      if ({in_ready, busy, out_valid, out_last, sa_clear, sa_weight_load} !== 6'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl_outs: got %b expected 000000",
                  {in_ready, busy, out_valid, out_last, sa_clear, sa_weight_load});
      end
      vectors++;
      if (sa_w !== 72'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_sa_w: got %h expected 0", sa_w);
      end
      vectors++;
      if ({out_data, sa_act_in, sa_psum_in} !== 72'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data_outs: got %h expected 0", {out_data, sa_act_in, sa_psum_in});
      end
      rst = 1'b0;
      step();
      vectors++;
      if ({cfg_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL reset_idle_after_release: got %b expected 10", {cfg_ready, busy});
      end
   endtask

   task automatic test_identity();
      logic [23:0] expAct [3];
      logic        expV;
      expAct[0] = 24'h000001;
      expAct[1] = 24'h000200;
      expAct[2] = 24'h030000;
      configureAndRun(W_IDENT);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ident_in_ready: got %b expected 1", in_ready);
      end
      applyStimulus(1'b1, 24'h030201, 1'b1);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) step();
         expV = (k == 6);
         if (k < 3) begin
            vectors++;
            if (sa_act_in !== expAct[k]) begin
               miscompares++;
               $display("[TB] FAIL ident_skew k=%0d: got %h expected %h", k, sa_act_in, expAct[k]);
            end
         end
         vectors++;
         if (out_valid !== expV) begin
            miscompares++;
            $display("[TB] FAIL ident_out_valid k=%0d: got %b expected %b", k, out_valid, expV);
         end
         if (k == 6) begin
            vectors++;
            if ({out_last, busy, out_data} !== {1'b1, 1'b0, 24'h030201}) begin
               miscompares++;
               $display("[TB] FAIL ident_result: got last=%b busy=%b data=%h expected last=1 busy=0 data=030201",
                        out_last, busy, out_data);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] expD [3];
      logic        expV;
      expD[0] = 24'h060606;
      expD[1] = 24'h0f0f0f;
      expD[2] = 24'h181818;
      configureAndRun(W_ONES);
      applyStimulus(1'b1, 24'h030201, 1'b0);
      step();
      applyStimulus(1'b1, 24'h060504, 1'b0);
      step();
      applyStimulus(1'b1, 24'h090807, 1'b1);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      for (int t = 3; t <= 10; t++) begin
         step();
         expV = (t >= 6 && t <= 8);
         vectors++;
         if (out_valid !== expV) begin
            miscompares++;
            $display("[TB] FAIL b2b_out_valid t=%0d: got %b expected %b", t, out_valid, expV);
         end
         if (expV) begin
            vectors++;
            if ({out_last, out_data} !== {(t == 8), expD[t-6]}) begin
               miscompares++;
               $display("[TB] FAIL b2b_result t=%0d: got last=%b data=%h expected last=%b data=%h",
                        t, out_last, out_data, (t == 8), expD[t-6]);
            end
         end
         if (t == 3 || t == 7 || t == 8) begin
            vectors++;
            if ({in_ready, busy} !== {1'b0, (t != 8)}) begin
               miscompares++;
               $display("[TB] FAIL b2b_drain t=%0d: got in_ready=%b busy=%b expected in_ready=0 busy=%b",
                        t, in_ready, busy, (t != 8));
            end
         end
      end
   endtask

   task automatic test_cfg_start_wrap();
      logic expV;
      cfg_weights = W_100;
      cfg_valid   = 1'b1;
      start       = 1'b1;
      step();
      cfg_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({sa_clear, sa_weight_load} !== {(k == 0), (k == 1)}) begin
            miscompares++;
            $display("[TB] FAIL cfgstart_pulses k=%0d: got clr=%b wl=%b expected clr=%b wl=%b",
                     k, sa_clear, sa_weight_load, (k == 0), (k == 1));
         end
         vectors++;
         if ({cfg_ready, sa_w} !== {1'b0, W_100}) begin
            miscompares++;
            $display("[TB] FAIL cfgstart_hold k=%0d: got ready=%b w=%h expected ready=0 w=%h",
                     k, cfg_ready, sa_w, W_100);
         end
         step();
         start       = 1'b0;
         cfg_weights = W_IDENT;
      end
      applyStimulus(1'b1, 24'h010101, 1'b1);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         step();
         expV = (k == 6);
         vectors++;
         if ({out_valid, cfg_ready} !== {expV, expV}) begin
            miscompares++;
            $display("[TB] FAIL wrap_valid_ready k=%0d: got %b%b expected %b%b",
                     k, out_valid, cfg_ready, expV, expV);
         end
         if (k == 6) begin
            vectors++;
            if (out_data !== 24'h2c2c2c) begin
               miscompares++;
               $display("[TB] FAIL wrap_data: got %h expected 2c2c2c", out_data);
            end
         end
      end
   endtask

   task automatic test_gapped_rerun();
      logic expV;
      configureAndRun(W_ONES);
      applyStimulus(1'b1, 24'h030201, 1'b0);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      step();
      applyStimulus(1'b1, 24'h060504, 1'b1);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      for (int t = 3; t <= 9; t++) begin
         step();
         expV = (t == 6 || t == 8);
         vectors++;
         if (out_valid !== expV) begin
            miscompares++;
            $display("[TB] FAIL gap_out_valid t=%0d: got %b expected %b", t, out_valid, expV);
         end
         if (expV) begin
            vectors++;
            if ({out_last, out_data} !== ((t == 6) ? {1'b0, 24'h060606} : {1'b1, 24'h0f0f0f})) begin
               miscompares++;
               $display("[TB] FAIL gap_result t=%0d: got last=%b data=%h", t, out_last, out_data);
            end
         end
      end
      cfg_weights = W_100;
      start       = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if ({sa_clear, sa_w} !== {1'b1, W_ONES}) begin
         miscompares++;
         $display("[TB] FAIL rerun_clear_w: got clr=%b w=%h expected clr=1 w=%h", sa_clear, sa_w, W_ONES);
      end
      step();
      vectors++;
      if (sa_weight_load !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rerun_weight_load: got %b expected 1", sa_weight_load);
      end
      step();
      applyStimulus(1'b1, 24'h090807, 1'b1);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         step();
         expV = (k == 6);
         vectors++;
         if (out_valid !== expV) begin
            miscompares++;
            $display("[TB] FAIL rerun_out_valid k=%0d: got %b expected %b", k, out_valid, expV);
         end
         if (k == 6) begin
            vectors++;
            if (out_data !== 24'h181818) begin
               miscompares++;
               $display("[TB] FAIL rerun_data: got %h expected 181818", out_data);
            end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      applyStimulus(1'b1, 24'h030201, 1'b0);
      step();
      applyStimulus(1'b1, 24'h060504, 1'b0);
      step();
      applyStimulus(1'b1, 24'h090807, 1'b0);
      step();
      applyStimulus(1'b0, 24'h0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({out_valid, out_last, out_data, sa_act_in} !== 50'h0) begin
         miscompares++;
         $display("[TB] FAIL midrst_data: got v=%b l=%b d=%h act=%h expected all 0",
                  out_valid, out_last, out_data, sa_act_in);
      end
      vectors++;
      if ({cfg_ready, in_ready, busy, sa_w} !== {3'b100, 72'h0}) begin
         miscompares++;
         $display("[TB] FAIL midrst_ctrl: got ready=%b in_ready=%b busy=%b w=%h expected 1 0 0 0",
                  cfg_ready, in_ready, busy, sa_w);
      end
      #2;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         vectors++;
         if ({out_valid, busy, cfg_ready} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL midrst_after k=%0d: got valid=%b busy=%b ready=%b expected 0 0 1",
                     k, out_valid, busy, cfg_ready);
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      cfg_valid   = 1'b0;
      start       = 1'b0;
      cfg_weights = '0;
      applyStimulus(1'b0, 24'h0, 1'b0);
      test_reset();
      test_identity();
      test_back_to_back();
      test_cfg_start_wrap();
      test_gapped_rerun();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
